// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO master.
//   - mdio_state_e : frame sequencer states
//   - ST/OP/TA field constants and field lengths
//   - build_frame(): the 32 post-preamble bits, MSB sent first
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        TA,
        DATA,
        DONE
    } mdio_state_e;

    localparam logic [1:0] ST_BITS  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    // For reads the TA/DATA part is never driven (oe=0), so its content is a don't-care.
    function automatic logic [31:0] build_frame(input logic        write,
                                                input logic [4:0]  phy_addr,
                                                input logic [4:0]  reg_addr,
                                                input logic [15:0] wr_data);
        return {ST_BITS, (write ? OP_WRITE : OP_READ), phy_addr, reg_addr, TA_WRITE, wr_data};
    endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Request/response bus between board-control logic and mdio_master.
//   start, write, phy_addr, reg_addr, wr_data : request (latched at start)
//   ready, rd_data, rd_valid                  : status / read result
//   skip_pre                                  : only with MDIO_PRE_SUPPRESS_EN
// Modports: master = requester, slave = mdio_master.
interface mdio_master_if;
    logic        start;
    logic        write;
    logic [4:0]  phy_addr;
    logic [4:0]  reg_addr;
    logic [15:0] wr_data;
    logic        ready;
    logic [15:0] rd_data;
    logic        rd_valid;
`ifdef MDIO_PRE_SUPPRESS_EN
    logic        skip_pre;

    modport master (output start, write, phy_addr, reg_addr, wr_data, skip_pre,
                    input  ready, rd_data, rd_valid);
    modport slave  (input  start, write, phy_addr, reg_addr, wr_data, skip_pre,
                    output ready, rd_data, rd_valid);
`else
    modport master (output start, write, phy_addr, reg_addr, wr_data,
                    input  ready, rd_data, rd_valid);
    modport slave  (input  start, write, phy_addr, reg_addr, wr_data,
                    output ready, rd_data, rd_valid);
`endif
endinterface

// File: rtl/mdio_clkgen.sv
// MDC generator: divides clock by 2*CLK_DIV while en=1.
//   clock, reset : system clock, sync active-high reset
//   en           : run the divider; when low the counter and mdc are held at 0
//   mdc          : management clock
//   rise_evt     : strobe on the clock edge where mdc toggles 0->1
//   fall_evt     : strobe on the clock edge where mdc toggles 1->0
module mdio_clkgen #(
    parameter int CLK_DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic mdc,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          mdc_q, mdc_d;
    logic          tc;

    always_comb begin
        tc        = en && (div_cnt_q == DW'(CLK_DIV - 1));
        div_cnt_d = '0;
        mdc_d     = 1'b0;
        if (en) begin
            div_cnt_d = tc ? '0 : div_cnt_q + DW'(1);
            mdc_d     = tc ? ~mdc_q : mdc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= '0;
            mdc_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            mdc_q     <= mdc_d;
        end
    end

    assign mdc      = mdc_q;
    assign rise_evt = tc & ~mdc_q;
    assign fall_evt = tc &  mdc_q;

endmodule

// File: rtl/mdio_master.sv
// IEEE 802.3 Clause 22 MDIO management master (read and write frames).
//   clock, reset : system clock, sync active-high reset
//   bus          : mdio_master_if.slave request/response bus
//   mdc          : management clock, clock/(2*CLK_DIV), low while idle
//   mdio_o/oe/i  : split MDIO pad (oe=1 drives mdio_o)
// Optional: `define MDIO_PRE_SUPPRESS_EN adds bus.skip_pre to omit the preamble.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV       = 10,
    parameter int PREAMBLE_BITS = 32
) (
    input  logic          clock,
    input  logic          reset,
    mdio_master_if.slave  bus,
    output logic          mdc,
    output logic          mdio_o,
    output logic          mdio_oe,
    input  logic          mdio_i
);

    mdio_state_e state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_sr_q, tx_sr_d;
    logic [15:0] rx_sr_q, rx_sr_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        is_wr_q, is_wr_d;
    logic        ready_q, ready_d;
    logic        rd_valid_q, rd_valid_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;

    logic        clk_en, rise_evt, fall_evt;
    logic        last_bit;
    logic [5:0]  field_last;

    assign clk_en = (state_q == PRE) || (state_q == HDR) || (state_q == TA) || (state_q == DATA);

    mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clock    (clock),
        .reset    (reset),
        .en       (clk_en),
        .mdc      (mdc),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt)
    );

    always_comb begin
        case (state_q)
            PRE:     field_last = 6'(PREAMBLE_BITS - 1);
            HDR:     field_last = 6'(HDR_BITS - 1);
            TA:      field_last = 6'(TA_BITS - 1);
            default: field_last = 6'(DATA_BITS - 1);
        endcase
        last_bit = (bit_cnt_q == field_last);
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rd_data_d  = rd_data_q;
        is_wr_d    = is_wr_q;
        ready_d    = ready_q;
        rd_valid_d = 1'b0;
        mdio_o_d   = mdio_o_q;
        mdio_oe_d  = mdio_oe_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ready_d   = 1'b0;
                    is_wr_d   = bus.write;
                    tx_sr_d   = build_frame(bus.write, bus.phy_addr, bus.reg_addr, bus.wr_data);
                    bit_cnt_d = '0;
                    mdio_oe_d = 1'b1;
`ifdef MDIO_PRE_SUPPRESS_EN
                    if (bus.skip_pre) begin
                        state_d  = HDR;
                        mdio_o_d = ST_BITS[1];
                    end else begin
                        state_d  = PRE;
                        mdio_o_d = 1'b1;
                    end
`else
                    state_d  = PRE;
                    mdio_o_d = 1'b1;
`endif
                end
            end

            PRE: begin
                if (fall_evt) begin
                    if (last_bit) begin
                        state_d   = HDR;
                        bit_cnt_d = '0;
                        mdio_o_d  = tx_sr_q[31];
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end

            HDR, TA, DATA: begin
                if (fall_evt) begin
                    if (last_bit && state_q == DATA) begin
                        // Last high half done: park the pad and publish a read result.
                        state_d   = DONE;
                        mdio_o_d  = 1'b1;
                        mdio_oe_d = 1'b0;
                        if (!is_wr_q) begin
                            rd_data_d  = rx_sr_q;
                            rd_valid_d = 1'b1;
                        end
                    end else begin
                        tx_sr_d   = tx_sr_q << 1;
                        bit_cnt_d = last_bit ? '0 : bit_cnt_q + 6'd1;
                        if (last_bit)
                            state_d = (state_q == HDR) ? TA : DATA;
                        // Reads release the line from the first TA bit onwards.
                        mdio_oe_d = is_wr_q || (state_q == HDR && !last_bit);
                        mdio_o_d  = mdio_oe_d ? tx_sr_q[30] : 1'b1;
                    end
                end
                if (rise_evt && state_q == DATA)
                    rx_sr_d = {rx_sr_q[14:0], mdio_i};
            end

            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rd_data_q  <= '0;
            is_wr_q    <= 1'b0;
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            mdio_o_q   <= 1'b1;
            mdio_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rd_data_q  <= rd_data_d;
            is_wr_q    <= is_wr_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
            mdio_o_q   <= mdio_o_d;
            mdio_oe_q  <= mdio_oe_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign mdio_o       = mdio_o_q;
    assign mdio_oe      = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master (CLK_DIV=2, PREAMBLE_BITS=32).
// A PHY model answers reads and records (mdio_o, mdio_oe) at every MDC rise;
// each frame is compared against the bit stream assembled from the frame fields.
module tb_mdio_master;

    localparam int CLK_DIV = 2;
    localparam int PRE     = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mdc, mdio_o, mdio_oe;
    logic mdio_i = 1'b1;

    mdio_master_if bus();

    mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_BITS(PRE)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .mdc     (mdc),
        .mdio_o  (mdio_o),
        .mdio_oe (mdio_oe),
        .mdio_i  (mdio_i)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- PHY model / line monitor ----------------
    logic [63:0] act_o, act_oe;
    int          nbits;
    int          rdv_cnt;
    logic [15:0] phy_val;
    int          pre_len = PRE;

    function automatic logic phy_bit(input int idx);
        if (idx >= pre_len + 16 && idx < pre_len + 32)
            return phy_val[15 - (idx - pre_len - 16)];
        return 1'b1;
    endfunction

    always @(posedge mdc) begin
        act_o  = {act_o[62:0], mdio_o};
        act_oe = {act_oe[62:0], mdio_oe};
        nbits++;
        mdio_i = phy_bit(nbits);   // next bit, stable well before the next rise
    end

    always @(negedge clock) if (bus.rd_valid) rdv_cnt++;

    // ---------------- reference frame ----------------
    logic [63:0] exp_o, exp_oe, len_mask;
    int          cur_len, c0;
    logic        cur_wr;
    logic [15:0] last_rd = 16'h0;

    task automatic prep(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input logic [15:0] pv, input logic sp);
        logic [13:0] hdr;
        logic [17:0] tail, tail_oe;
        bus.write    = wr;
        bus.phy_addr = pa;
        bus.reg_addr = ra;
        bus.wr_data  = wd;
`ifdef MDIO_PRE_SUPPRESS_EN
        bus.skip_pre = sp;
        pre_len      = sp ? 0 : PRE;
`else
        pre_len      = PRE;
`endif
        phy_val = pv;
        act_o   = '0;
        act_oe  = '0;
        nbits   = 0;
        rdv_cnt = 0;
        mdio_i  = 1'b1;
        cur_wr  = wr;
        hdr     = {2'b01, (wr ? 2'b01 : 2'b10), pa, ra};
        tail    = wr ? {2'b10, wd} : 18'h0;
        tail_oe = wr ? 18'h3FFFF : 18'h0;
        exp_o   = {32'hFFFF_FFFF, hdr, tail};
        exp_oe  = {32'hFFFF_FFFF, 14'h3FFF, tail_oe};
        cur_len = pre_len + 32;
        len_mask = (cur_len == 64) ? '1 : ((64'd1 << cur_len) - 64'd1);
        c0      = cyc;
    endtask

    task automatic launch(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input logic [15:0] pv, input logic sp);
        @(negedge clock);
        prep(wr, pa, ra, wd, pv, sp);
        bus.start = 1'b1;
    endtask

    // Wait for the frame to end and check everything about it.
    task automatic complete(input string nm, input bit hold, input bit mid, input logic [15:0] exp_rd);
        int n;
        @(negedge clock);
        if (!hold) bus.start = 1'b0;
        chk({nm, " ready_low"}, 64'(bus.ready), 64'd0);
        n = 0;
        while (!bus.ready && n < 5000) begin
            if (mid && n == 100) begin
                bus.start    = 1'b1;
                bus.write    = ~bus.write;
                bus.phy_addr = ~bus.phy_addr;
            end
            if (mid && n == 101) bus.start = 1'b0;
            @(negedge clock);
            n++;
        end
        chk({nm, " ready_time"}, 64'(cyc - c0), 64'(cur_len * 2 * CLK_DIV + 2));
        chk({nm, " nbits"},      64'(nbits), 64'(cur_len));
        chk({nm, " oe_stream"},  act_oe & len_mask, exp_oe & len_mask);
        chk({nm, " o_stream"},   act_o & exp_oe & len_mask, exp_o & exp_oe & len_mask);
        chk({nm, " rd_valid"},   64'(rdv_cnt), cur_wr ? 64'd0 : 64'd1);
        chk({nm, " rd_data"},    64'(bus.rd_data), 64'(exp_rd));
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  pa, ra;
        logic [15:0] wd, pv;
        bit          mid;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic        rwr;
        logic [15:0] rpv;
        int          n;

        tbl[0] = '{1'b0, 5'h01, 5'h02, 16'h0000, 16'h796D, 1'b1, 16'h796D};
        tbl[1] = '{1'b1, 5'h1F, 5'h00, 16'hA5A5, 16'h0000, 1'b1, 16'h796D};
        tbl[2] = '{1'b0, 5'h1F, 5'h1F, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};
        tbl[3] = '{1'b1, 5'h00, 5'h1F, 16'h0000, 16'h1234, 1'b0, 16'hFFFF};
        tbl[4] = '{1'b0, 5'h00, 5'h00, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[5] = '{1'b1, 5'h15, 5'h0A, 16'hFFFF, 16'h0000, 1'b0, 16'h0000};

        bus.start = 1'b0; bus.write = 1'b0; bus.phy_addr = '0; bus.reg_addr = '0; bus.wr_data = '0;
`ifdef MDIO_PRE_SUPPRESS_EN
        bus.skip_pre = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst ready",    64'(bus.ready),    64'd1);
        chk("rst rd_data",  64'(bus.rd_data),  64'd0);
        chk("rst rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst mdc",      64'(mdc),          64'd0);
        chk("rst mdio_o",   64'(mdio_o),       64'd1);
        chk("rst mdio_oe",  64'(mdio_oe),      64'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].wr, tbl[i].pa, tbl[i].ra, tbl[i].wd, tbl[i].pv, 1'b0);
            complete($sformatf("vec%0d", i), 1'b0, tbl[i].mid, tbl[i].exp_rd);
        end
        last_rd = 16'h0000;

        // Reset in the middle of a read's DATA phase.
        launch(1'b0, 5'h03, 5'h04, 16'h0, 16'hBEEF, 1'b0);
        @(negedge clock);
        bus.start = 1'b0;
        n = 0;
        while (cyc < c0 + 1 + (PRE + 20) * 2 * CLK_DIV && n < 5000) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        @(negedge clock);
        chk("midrst mdc",      64'(mdc),         64'd0);
        chk("midrst oe",       64'(mdio_oe),     64'd0);
        chk("midrst o",        64'(mdio_o),      64'd1);
        chk("midrst ready",    64'(bus.ready),   64'd1);
        chk("midrst rd_data",  64'(bus.rd_data), 64'd0);
        chk("midrst rd_valid", 64'(rdv_cnt),     64'd0);
        reset = 1'b0;
        last_rd = 16'h0;
        launch(1'b0, 5'h03, 5'h04, 16'h0, 16'h5A3C, 1'b0);
        complete("post_rst", 1'b0, 1'b0, 16'h5A3C);
        last_rd = 16'h5A3C;

        // Back-to-back with start held high.
        launch(1'b1, 5'h0C, 5'h11, 16'hC3C3, 16'h0, 1'b0);
        complete("b2b_a", 1'b1, 1'b0, last_rd);
        chk("b2b gap mdc", 64'(mdc), 64'd0);
        prep(1'b0, 5'h07, 5'h19, 16'h0, 16'h0F1E, 1'b0);
        complete("b2b_b", 1'b0, 1'b0, 16'h0F1E);
        chk("b2b_b started", 64'(nbits > 0), 64'd1);
        last_rd = 16'h0F1E;

        // Randomized frames against the field-level model.
        for (int i = 0; i < 8; i++) begin
            rwr = 1'($urandom_range(0, 1));
            rpv = 16'($urandom);
            launch(rwr, 5'($urandom), 5'($urandom), 16'($urandom), rpv, 1'b0);
            if (!rwr) last_rd = rpv;
            complete($sformatf("rnd%0d", i), 1'b0, 1'b0, last_rd);
        end

`ifdef MDIO_PRE_SUPPRESS_EN
        launch(1'b0, 5'h02, 5'h05, 16'h0, 16'h8001, 1'b1);
        complete("skip_pre1", 1'b0, 1'b0, 16'h8001);
        launch(1'b1, 5'h02, 5'h05, 16'h1357, 16'h0, 1'b0);
        complete("skip_pre0", 1'b0, 1'b0, 16'h8001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
